// File: rtl/vibration_counter_bcd.sv
// vibration_counter_bcd: synchronised, hold-off filtered rising-edge
// counter on the vibration sensor line, with a packed BCD count.
module vibration_counter_bcd #(
  parameter int DIGITS      = 4,
  parameter int HOLDOFF     = 16,
  parameter int SAT_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sensor_in,
  input  logic                en,
  input  logic                clr,
  output logic [4*DIGITS-1:0] count_out,
  output logic                event_pulse,
  output logic                overflow,
  output logic                busy
);

  localparam int          W       = 4 * DIGITS;
  localparam logic [15:0] HOLD_LD = 16'(HOLDOFF);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   s;
  logic                   prev;
  logic                   armed;
  logic                   primed;
  logic                   rise;
  logic                   accept;
  logic                   all9;
  logic                   carry;
  logic [15:0]            hold;
  logic [15:0]            hold_nxt;
  logic [W-1:0]           inc;

  assign s      = sync_q[SYNC_STAGES-1];
  assign primed = fill_q[SYNC_STAGES-1];
  assign rise   = s & ~prev;
  assign accept = rise & armed & en & (hold == '0) & ~clr;

  always_comb begin
    carry = 1'b1;
    all9  = 1'b1;
    inc   = count_out;
    for (int i = 0; i < DIGITS; i++) begin
      all9 = all9 & (count_out[4*i +: 4] == 4'd9);
      if (carry) begin
        if (count_out[4*i +: 4] == 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = count_out[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    hold_nxt = hold;
    if (clr)
      hold_nxt = '0;
    else if (accept)
      hold_nxt = HOLD_LD;
    else if (hold != '0)
      hold_nxt = hold - 16'd1;
  end

  // s is trusted for arming only once the chain holds real samples,
  // so a line already high at reset release never arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      fill_q      <= '0;
      prev        <= 1'b0;
      armed       <= 1'b0;
      hold        <= '0;
      busy        <= 1'b0;
      event_pulse <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sensor_in};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev        <= s;
      armed       <= armed | (primed & ~s);
      hold        <= hold_nxt;
      busy        <= (hold_nxt != '0);
      event_pulse <= accept;
      if (clr) begin
        count_out <= '0;
        overflow  <= 1'b0;
      end else if (accept) begin
        if (all9)
          overflow <= 1'b1;
        if (!(all9 && SAT_MODE != 0))
          count_out <= inc;
      end
    end
  end

endmodule

// File: doc/vibration_counter_bcd.md
# vibration_counter_bcd

Parametrised, clock-synchronous vibration-event counter for the expansion-board sensor demos. It samples the raw vibration sensor line, synchronises it, and detects rising edges. A programmable hold-off window rejects contact bounce, and accepted events are counted in a DIGITS-wide packed BCD counter that drives the 7-segment display path. The block adds a sync clear, a count enable, a wrap or saturate mode, and a sticky overflow flag.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1..8.
- HOLDOFF, 16: lockout cycles after an accepted event; legal range 0..65535; 0 means no lockout.
- SAT_MODE, 0: 0 = wrap all-9s -> 0; 1 = hold at all-9s.
- SYNC_STAGES, 2: synchroniser depth; minimum 2.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sensor_in  in  1  raw sensor line, asynchronous to clk.
- en  in  1  count enable; high = edges may be accepted.
- clr  in  1  synchronous clear of count, overflow and hold-off.
- count_out  out  4*DIGITS  packed BCD count; digit 0 is in bits [3:0].
- event_pulse  out  1  one-cycle strobe per accepted event.
- overflow  out  1  sticky; set when an event arrives at all-9s.
- busy  out  1  high while the hold-off window is active.

## Operation
- Reset (rst_n low, asynchronous): count_out=0, event_pulse=0, overflow=0, busy=0, hold-off counter=0, synchroniser and previous-sample registers=0, armed=0.
- Synchroniser: a SYNC_STAGES-deep shift register produces s (the last stage).
- Edge detect: prev is a registered copy of s; rise = s & ~prev.
- Armed flag: set on the first clock where s==0 after reset. A rise is ignored while armed=0, so a line that is already high at reset release is not counted.
- Accept condition: accept = rise & armed & en & (hold==0) & ~clr.
- On accept:
  - Load hold with HOLDOFF.
  - Increment the count by one in BCD. A digit at 9 rolls to 0 and carries; the whole ripple completes within one cycle.
  - Register event_pulse=1 for exactly one cycle.
- Hold-off: when hold!=0, it decrements by 1 every cycle, independent of en. Rises during hold-off are discarded, not queued.
- Count at all-9s when an event is accepted:
  - Both modes: overflow is set.
  - SAT_MODE=0: count wraps to 0.
  - SAT_MODE=1: count stays at all-9s.
  - event_pulse asserts in both modes.
- Overflow stays set until clr or reset.
- clr: on the next edge, count=0, overflow=0, hold=0. clr does not affect the synchroniser, prev or armed.
  - clr coincident with a rise: clr wins; no count and no event_pulse.
- en low: rises are discarded, the hold-off counter still runs, and count holds its value.
- busy = (hold != 0), driven from a register.
- BCD digits never hold 0xA..0xF.

## Timing
- Latency: sensor_in goes high with setup before edge E0 and the previous input was low, armed=1, not in hold-off.
  - s rises after edge E0+SYNC_STAGES-1.
  - count_out updates and event_pulse goes high after edge E0+SYNC_STAGES, for one cycle.
- Minimum spacing between accepted events is HOLDOFF+1 cycles. busy is high for exactly HOLDOFF cycles after the accepting edge.
- Throughput with HOLDOFF=0: one event per two cycles maximum, because a rise needs the sampled line to go low and high again.
- Pulses on sensor_in shorter than one clk period may be missed; this is permitted.
- Reset asserted mid-operation clears all state immediately. The first count after release requires the line to be seen low, then high.

## Test plan
- Reset/latency: DIGITS=4, SYNC_STAGES=2, HOLDOFF=0. Release reset with sensor_in low, then raise it before edge 10 -> count_out=0x0001 and event_pulse high after edge 12 only.
- Hold-off: HOLDOFF=16. Apply 5 rises spaced 4 cycles apart within 20 cycles -> count=0x0001, busy high for 16 cycles. Apply a rise 17 cycles after the first accept -> count=0x0002.
- Wrap: SAT_MODE=0, preload by 9999 events, then 1 more -> count=0x0000, overflow=1. Assert clr -> overflow=0.
- Saturate: SAT_MODE=1, DIGITS=2, apply 101 events -> count=0x99, overflow=1, 101 event_pulses.
- Arming and controls: sensor_in high through reset release -> no count until a low-high transition. A rise with en=0 -> no count. clr and a rise in the same cycle -> count=0, no event_pulse.
- BCD carry: apply 109 events -> count=0x0109, no digit ever exceeds 9.
